// File: rtl/boxcar_decimator.sv
// Boxcar average-and-decimate by 2^LOG2_DECIM with a show-ahead output FIFO.
// Define BOXCAR_DECIMATOR_ROUND_EN for round-half-up instead of floor.
module boxcar_decimator #(
   parameter int SIGNAL_BITS = 24,
   parameter int LOG2_DECIM  = 4,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          strobe_i,
   input  logic signed [SIGNAL_BITS-1:0] signal_i,
   input  logic                          clear_i,
   output logic signed [SIGNAL_BITS-1:0] signal_o,
   output logic                          valid_o,
   input  logic                          ready_i,
   output logic                          overflow_o
);

   localparam int ACC_BITS = SIGNAL_BITS + LOG2_DECIM;
   localparam int PTR_BITS = $clog2(FIFO_DEPTH);

   logic signed [ACC_BITS-1:0]    acc;
   logic signed [ACC_BITS-1:0]    sum;
   logic signed [ACC_BITS-1:0]    rnd;
   logic        [SIGNAL_BITS-1:0] result;
   logic        [LOG2_DECIM-1:0]  cnt;
   logic        [PTR_BITS:0]      wr_ptr;
   logic        [PTR_BITS:0]      rd_ptr;
   logic        [SIGNAL_BITS-1:0] mem [FIFO_DEPTH];
   logic                          last;
   logic                          full;
   logic                          push;
   logic                          pop;
   logic                          wr_en;

   assign sum  = acc + {{LOG2_DECIM{signal_i[SIGNAL_BITS-1]}}, signal_i};
   assign last = (cnt == {LOG2_DECIM{1'b1}});

`ifdef BOXCAR_DECIMATOR_ROUND_EN
   localparam logic [ACC_BITS-1:0] HALF = ACC_BITS'(1) << (LOG2_DECIM - 1);
   assign rnd = sum + HALF;
`else
   assign rnd = sum;
`endif

   assign result = SIGNAL_BITS'(rnd >>> LOG2_DECIM);

   assign valid_o = (wr_ptr != rd_ptr);
   assign full    = (wr_ptr[PTR_BITS] != rd_ptr[PTR_BITS]) &&
                    (wr_ptr[PTR_BITS-1:0] == rd_ptr[PTR_BITS-1:0]);
   assign pop     = valid_o && ready_i;
   assign push    = strobe_i && last;
   // A full FIFO can still take the result if its head leaves on this edge.
   assign wr_en   = push && (!full || pop);

   assign signal_o = mem[rd_ptr[PTR_BITS-1:0]];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc        <= '0;
         cnt        <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         overflow_o <= 1'b0;
      end else if (clear_i) begin
         acc        <= '0;
         cnt        <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         overflow_o <= 1'b0;
      end else begin
         if (strobe_i) begin
            if (last) begin
               acc <= '0;
               cnt <= '0;
            end else begin
               acc <= sum;
               cnt <= cnt + 1'b1;
            end
         end
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         if (push && full && !pop) overflow_o <= 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else if (wr_en && !clear_i) begin
         mem[wr_ptr[PTR_BITS-1:0]] <= result;
      end
   end

endmodule

// File: tb/tb_boxcar_decimator.sv
// Directed bench for boxcar_decimator (N=4, depth 4, 24-bit samples).
// Expected values follow BOXCAR_DECIMATOR_ROUND_EN when it is defined.
module tb_boxcar_decimator;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               strobe;
   logic signed [23:0] sig_in;
   logic               clear;
   logic signed [23:0] sig_out;
   logic               valid;
   logic               ready;
   logic               overflow;

   int tests = 0;
   int fails = 0;

   boxcar_decimator #(
      .SIGNAL_BITS(24),
      .LOG2_DECIM (2),
      .FIFO_DEPTH (4)
   ) dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .strobe_i  (strobe),
      .signal_i  (sig_in),
      .clear_i   (clear),
      .signal_o  (sig_out),
      .valid_o   (valid),
      .ready_i   (ready),
      .overflow_o(overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe_one(input logic signed [23:0] v);
      strobe = 1'b1;
      sig_in = v;
      tick();
      strobe = 1'b0;
   endtask

   task automatic block(input logic signed [23:0] v);
      for (int i = 0; i < 4; i++) strobe_one(v);
   endtask

   task automatic pop_expect(input string tag, input logic signed [31:0] v);
      check({tag, "_valid"}, 32'(valid), 1);
      check({tag, "_data"}, 32'(sig_out), v);
      ready = 1'b1;
      tick();
      ready = 1'b0;
   endtask

   initial begin
      rst_n  = 1'b0;
      strobe = 1'b0;
      sig_in = '0;
      clear  = 1'b0;
      ready  = 1'b0;
      #1;
      check("rst_valid", 32'(valid), 0);
      check("rst_ovf", 32'(overflow), 0);
      check("rst_data", 32'(sig_out), 0);
      tick();
      rst_n = 1'b1;
      tick();

      strobe_one(10);
      strobe_one(20);
      strobe_one(30);
      check("partial_block", 32'(valid), 0);
      strobe_one(42);
`ifdef BOXCAR_DECIMATOR_ROUND_EN
      pop_expect("avg_pos", 26);
`else
      pop_expect("avg_pos", 25);
`endif
      check("empty_after_pop", 32'(valid), 0);

      strobe_one(-1);
      strobe_one(-1);
      strobe_one(-1);
      strobe_one(-2);
`ifdef BOXCAR_DECIMATOR_ROUND_EN
      pop_expect("avg_neg", -1);
`else
      pop_expect("avg_neg", -2);
`endif

      // Gaps between strobes must not end a block.
      strobe_one(1);
      tick();
      tick();
      strobe_one(2);
      tick();
      strobe_one(3);
      tick();
      tick();
      tick();
      check("gap_partial", 32'(valid), 0);
      strobe_one(6);
      pop_expect("gap_block", 3);

      // Clear with a coincident strobe discards the partial block.
      strobe_one(50);
      strobe_one(50);
      clear = 1'b1;
      strobe_one(50);
      clear = 1'b0;
      block(8);
      pop_expect("clear_mid", 8);
      check("clear_mid_empty", 32'(valid), 0);

      for (int i = 0; i < 16; i++) strobe_one(7);
      check("full_no_ovf", 32'(overflow), 0);
      for (int i = 0; i < 4; i++) strobe_one(7);
      check("ovf_set", 32'(overflow), 1);
      check("ovf_valid", 32'(valid), 1);
      check("ovf_head", 32'(sig_out), 7);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("clear_valid", 32'(valid), 0);
      check("clear_ovf", 32'(overflow), 0);

      block(1);
      block(2);
      block(3);
      block(4);
      strobe_one(5);
      strobe_one(5);
      strobe_one(5);
      ready = 1'b1;
      strobe_one(5);
      ready = 1'b0;
      check("pushpop_ovf", 32'(overflow), 0);
      pop_expect("pp0", 2);
      pop_expect("pp1", 3);
      pop_expect("pp2", 4);
      pop_expect("pp3", 5);
      check("pp_empty", 32'(valid), 0);

      strobe_one(5);
      strobe_one(5);
      rst_n = 1'b0;
      #1;
      check("rst2_valid", 32'(valid), 0);
      tick();
      rst_n = 1'b1;
      tick();
      block(100);
      pop_expect("after_rst", 100);
      check("after_rst_empty", 32'(valid), 0);

      block(24'sd8388607);
      pop_expect("max_pos", 8388607);
      block(-24'sd8388608);
      pop_expect("max_neg", -8388608);
      check("final_ovf", 32'(overflow), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/boxcar_decimator.md
BOXCAR_DECIMATOR -- requirements
Module: boxcar_decimator

Interface
REQ-001 SHALL have parameter SIGNAL_BITS, default 24, width of signed input and output samples.
REQ-002 SHALL have parameter LOG2_DECIM, default 4, range 1..8; decimation ratio N = 2^LOG2_DECIM.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, power of two, at least 2; output buffer entries.
REQ-004 SHALL have port clk_i, input, 1 bit: single clock, all logic on rising edge.
REQ-005 SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port strobe_i, input, 1 bit: one-cycle sample-valid pulse; driven by the upstream IIR filter's done strobe.
REQ-007 SHALL have port signal_i, input, SIGNAL_BITS bits, signed: sample, sampled only when strobe_i=1.
REQ-008 SHALL have port clear_i, input, 1 bit: synchronous flush.
REQ-009 SHALL have port signal_o, output, SIGNAL_BITS bits, signed: FIFO head (show-ahead).
REQ-010 SHALL have port valid_o, output, 1 bit: FIFO not empty.
REQ-011 SHALL have port ready_i, input, 1 bit: consumer accepts head when valid_o=1 and ready_i=1.
REQ-012 SHALL have port overflow_o, output, 1 bit: sticky flag, a decimated result was dropped.

Function
REQ-013 SHALL keep a signed accumulator of SIGNAL_BITS+LOG2_DECIM bits and a LOG2_DECIM-bit sample counter.
REQ-014 On strobe_i=1 with counter < N-1: acc <= acc + signal_i (sign-extended); counter increments.
REQ-015 On strobe_i=1 with counter = N-1: sum = acc + signal_i; result = sum arithmetically shifted right by LOG2_DECIM (see REQ-024); acc <= 0; counter <= 0; push result at the same edge.
REQ-016 Latency: valid_o SHALL assert on the cycle after the edge closing the block, if FIFO was empty.
REQ-017 strobe_i=0: accumulator and counter hold; no gap or timeout ends a block.
REQ-018 Pop SHALL occur on any edge with valid_o=1 and ready_i=1; signal_o undefined-but-stable when valid_o=0.
REQ-019 FIFO full, push, no pop: result SHALL be dropped, FIFO contents unchanged, overflow_o <= 1.
REQ-020 FIFO full, push and pop on the same edge: push SHALL be accepted, overflow_o unchanged.
REQ-021 FIFO empty, pop requested: impossible by REQ-018 (valid_o=0); no state change.
REQ-022 clear_i=1: acc, counter, FIFO pointers, overflow_o cleared at that edge; a coincident strobe_i or push SHALL be discarded; clear_i has priority over all.
REQ-023 Pointers SHALL wrap modulo FIFO_DEPTH; full/empty distinguished by an extra pointer bit or occupancy count.

Configuration
REQ-024 Macro BOXCAR_DECIMATOR_ROUND_EN defined: result = (sum + 2^(LOG2_DECIM-1)) >>> LOG2_DECIM (round half up); undefined: result = sum >>> LOG2_DECIM (floor, truncation).
REQ-025 Neither mode SHALL overflow the accumulator or the output width; no saturation logic is required.

Reset
REQ-026 rst_ni low SHALL asynchronously clear acc, counter, FIFO pointers, valid_o=0, overflow_o=0, signal_o=0; a partially accumulated block SHALL be lost.
REQ-027 After rst_ni deasserts, the first strobe SHALL start a new block at counter 0.

Verification (LOG2_DECIM=2, FIFO_DEPTH=4, SIGNAL_BITS=24)
REQ-028 Strobes 10,20,30,42 -> one output: 25 without macro, 26 with BOXCAR_DECIMATOR_ROUND_EN.
REQ-029 Strobes -1,-1,-1,-2 -> -2 without macro, -1 with macro.
REQ-030 ready_i=0, 20 strobes of 7 -> 4 entries of 7, fifth result dropped, overflow_o=1; clear_i -> valid_o=0, overflow_o=0.
REQ-031 FIFO full, ready_i=1 on the edge of a fifth push -> 4 entries remain, newest result at tail, overflow_o=0.
REQ-032 2 strobes of 5, rst_ni pulsed low, then 4 strobes of 100 -> exactly one output, 100.
REQ-033 4 strobes of 8388607 -> 8388607; 4 strobes of -8388608 -> -8388608, both modes.
